// File: rtl/moore_rr_arbiter_pkg.sv
// moore_rr_arbiter_pkg: state codes, one-hot grants and the rotation search shared by the arbiter
package moore_rr_arbiter_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G1 = 2'd1;
   localparam logic [1:0] S_G2 = 2'd2;
   localparam logic [1:0] S_G3 = 2'd3;
   localparam logic [3:1] G_NONE = 3'b000;
   localparam logic [3:1] G_1 = 3'b001;
   localparam logic [3:1] G_2 = 3'b010;
   localparam logic [3:1] G_3 = 3'b100;

   function automatic logic [1:0] succ(input logic [1:0] k);
      return k == S_G3 ? S_G1 : k + 2'd1;
   endfunction

   function automatic logic [3:1] grant(input logic [1:0] s);
      return s == S_G1 ? G_1 : s == S_G2 ? G_2 : s == S_G3 ? G_3 : G_NONE;
   endfunction

   // first asserted requester in the order base+1, base+2, base; S_IDLE if none
   function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:1] r);
      logic [1:0] a, b;
      a = succ(base);
      b = succ(a);
      return |(r & grant(a)) ? a : |(r & grant(b)) ? b : |(r & grant(base)) ? base : S_IDLE;
   endfunction
endpackage

// File: rtl/moore_rr_arbiter_hold_counter.sv
// moore_rr_arbiter_hold_counter: saturating grant-hold counter that flags the last allowed cycle
module moore_rr_arbiter_hold_counter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W = 3
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);
   assign expired = cnt == CNT_W'(MAX_HOLD - 1);

   always_ff @(posedge Clock)
      if (!Resetn || clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/moore_rr_arbiter.sv
// moore_rr_arbiter: Moore round-robin arbiter over three requesters with bounded grant hold
module moore_rr_arbiter
   import moore_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W = 3
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [3:1] r,
   output logic [3:1] g,
   output logic       busy,
   output logic [1:0] owner
);
   logic [1:0] state, state_nxt, last;
   logic [CNT_W-1:0] hold_cnt;
   logic expired, own, others;

   moore_rr_arbiter_hold_counter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_hold (
      .Clock(Clock),
      .Resetn(Resetn),
      .clr(state_nxt != state),
      .en(state != S_IDLE),
      .cnt(hold_cnt),
      .expired(expired)
   );

   // last follows the current owner and survives a drop to IDLE for fairness
   always_ff @(posedge Clock)
      if (!Resetn) begin
         state <= S_IDLE;
         last <= S_G3;
      end else begin
         state <= state_nxt;
         if (state_nxt != S_IDLE) last <= state_nxt;
      end

   // searching from the current owner puts it last, so forced rotation never re-grants it while others wait
   always_comb begin
      own = |(r & grant(state));
      others = |(r & ~grant(state));
      state_nxt = state == S_IDLE ? pick(last, r) :
                  (!own || (others && expired)) ? pick(state, r) : state;
   end

   always_comb begin
      g = grant(state);
      busy = state != S_IDLE;
      owner = state;
   end
endmodule

// File: tb/tb_moore_rr_arbiter.sv
// tb_moore_rr_arbiter: directed-vector bench for the round-robin arbiter
module tb_moore_rr_arbiter;
   logic Clock, Resetn, busy;
   logic [3:1] r, g;
   logic [1:0] owner;
   int n_checks = 0;
   int n_fail = 0;

   moore_rr_arbiter #(.MAX_HOLD(8), .CNT_W(3)) dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .r(r),
      .g(g),
      .busy(busy),
      .owner(owner)
   );

   initial begin
      Clock = 0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_out(input string tag, input int eg, input int eo);
      check({tag, ".g"}, int'(g), eg);
      check({tag, ".owner"}, int'(owner), eo);
      check({tag, ".busy"}, int'(busy), int'(eg != 0));
   endtask

   initial begin
      Resetn = 0;
      r = 3'b111;
      tick();
      check_out("reset1", 0, 0);
      tick();
      check_out("reset2", 0, 0);
      Resetn = 1;
      r = 3'b010;
      tick();
      check_out("single_r2", 3'b010, 2);
      r = 3'b000;
      tick();
      check_out("release_idle", 0, 0);
      Resetn = 0;
      tick();
      Resetn = 1;
      r = 3'b111;
      for (int o = 0; o < 3; o++)
         for (int c = 0; c < 8; c++) begin
            tick();
            check_out($sformatf("rot_o%0d_c%0d", o, c), 1 << o, o + 1);
         end
      tick();
      check_out("rot_wrap", 3'b001, 1);
      r = 3'b001;
      for (int c = 0; c < 20; c++) begin
         tick();
         check($sformatf("sat_c%0d", c), int'(g), 3'b001);
      end
      r = 3'b011;
      tick();
      check_out("expired_rotate", 3'b010, 2);
      r = 3'b001;
      tick();
      check_out("handover_to1", 3'b001, 1);
      r = 3'b100;
      tick();
      check_out("handover_to3", 3'b100, 3);
      r = 3'b101;
      for (int c = 0; c < 7; c++) begin
         tick();
         check($sformatf("hold3_c%0d", c), int'(g), 3'b100);
      end
      tick();
      check_out("hold3_rotate", 3'b001, 1);
      r = 3'b000;
      tick();
      check_out("drop_idle", 0, 0);
      r = 3'b011;
      tick();
      check_out("last_kept", 3'b010, 2);
      for (int c = 0; c < 2; c++) begin
         tick();
         check($sformatf("g2_c%0d", c), int'(g), 3'b010);
      end
      Resetn = 0;
      r = 3'b111;
      tick();
      check_out("midgrant_reset", 0, 0);
      Resetn = 1;
      r = 3'b011;
      tick();
      check_out("after_reset", 3'b001, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
